// File: rtl/ei_axi4_pkg.sv
// ei_axi4_pkg: shared types for the AXI4 slave memory model.
// Burst and response encodings plus the write/read FSM state enums.
package ei_axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_type_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } response_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/ei_axi4_burst_addr_gen.sv
// ei_axi4_burst_addr_gen: next beat address, range check and burst legality.
// Ports: addr/len/size/burst in; next_addr, in_range (addr inside memory), legal out.
module ei_axi4_burst_addr_gen
    import ei_axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  burst_type_e           burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  in_range,
    output logic                  legal
);

    localparam int BYTE_LANES = DATA_WIDTH / 8;
    localparam int LANE_BITS  = $clog2(BYTE_LANES);
    localparam int MEM_BYTES  = MEM_DEPTH * BYTE_LANES;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        aligned   = addr & ~(step - ADDR_WIDTH'(1));
        incr      = aligned + step;
        // window size is (len+1) beats of 2^size bytes
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size)
                    - ADDR_WIDTH'(1);
        next_addr = incr;
        unique case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr;
            BURST_WRAP:  next_addr = (aligned & ~wrap_mask)
                                   | (incr & wrap_mask);
            BURST_RSVD:  next_addr = incr;
        endcase
        legal = (size <= 3'(LANE_BITS))
             && (burst != BURST_RSVD)
             && ((burst != BURST_WRAP)
                 || (len inside {8'd1, 8'd3, 8'd7, 8'd15}));
        in_range = {1'b0, addr} < (ADDR_WIDTH + 1)'(MEM_BYTES);
    end

endmodule

// File: rtl/ei_axi4_slave_mem.sv
// ei_axi4_slave_mem: AXI4 slave with internal byte-addressable memory.
// Ports: aclk/aresetn; AW, W, B write channels; AR, R read channels.
// Independent write (AW/W/B) and read (AR/R) FSMs, one burst each.
// Define EI_AXI4_SLV_WAIT_EN to insert WAIT_CYCLES stalls before each beat.
module ei_axi4_slave_mem
    import ei_axi4_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BYTE_LANES = DATA_WIDTH / 8;
    localparam int LANE_BITS  = $clog2(BYTE_LANES);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
`ifdef EI_AXI4_SLV_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam int         STALL     = WAIT_EN ? WAIT_CYCLES : 0;
    localparam bit         NO_STALL  = (STALL == 0);
    localparam logic [7:0] WAIT_LAST = 8'(STALL - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // write side state
    w_state_e              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    burst_type_e           w_burst;
    logic [7:0]            w_cnt;
    logic [7:0]            w_wait;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_next;
    logic                  w_in_range;
    logic                  w_legal;
    logic                  w_beat;
    logic                  w_beat_err;
    logic                  w_we;
    logic [IDX_W-1:0]      w_idx;

    // read side state
    r_state_e              r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    burst_type_e           r_burst;
    logic [7:0]            r_cnt;
    logic [7:0]            r_wait;
    logic [ADDR_WIDTH-1:0] r_gen_addr;
    logic [7:0]            r_gen_len;
    logic [2:0]            r_gen_size;
    burst_type_e           r_gen_burst;
    logic [ID_WIDTH-1:0]   r_id_sel;
    logic [7:0]            r_cnt_sel;
    logic [ADDR_WIDTH-1:0] r_next;
    logic                  r_in_range;
    logic                  r_legal;
    logic                  r_ok;
    logic                  r_fetch;
    logic [IDX_W-1:0]      r_idx;

    ei_axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_w_gen (
        .addr      (w_addr),
        .len       (w_len),
        .size      (w_size),
        .burst     (w_burst),
        .next_addr (w_next),
        .in_range  (w_in_range),
        .legal     (w_legal)
    );

    ei_axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_r_gen (
        .addr      (r_gen_addr),
        .len       (r_gen_len),
        .size      (r_gen_size),
        .burst     (r_gen_burst),
        .next_addr (r_next),
        .in_range  (r_in_range),
        .legal     (r_legal)
    );

    always_comb begin
        w_beat     = (w_state == W_DATA) && wready && wvalid;
        w_beat_err = !w_legal || !w_in_range
                  || (wlast != (w_cnt == w_len));
        w_we       = aresetn && w_beat && w_legal && w_in_range;
        w_idx      = w_addr[LANE_BITS +: IDX_W];
    end

    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (wstrb[i]) begin
                    mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bid     <= '0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= 8'd0;
            w_size  <= 3'd0;
            w_burst <= BURST_FIXED;
            w_cnt   <= 8'd0;
            w_wait  <= 8'd0;
            w_err   <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        w_id    <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= burst_type_e'(awburst);
                        w_cnt   <= 8'd0;
                        w_wait  <= 8'd0;
                        w_err   <= 1'b0;
                        wready  <= NO_STALL;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (!wready) begin
                        w_wait <= w_wait + 8'd1;
                        if (w_wait == WAIT_LAST) begin
                            wready <= 1'b1;
                        end
                    end else if (wvalid) begin
                        w_addr <= w_next;
                        w_cnt  <= w_cnt + 8'd1;
                        w_wait <= 8'd0;
                        if (w_beat_err) begin
                            w_err <= 1'b1;
                        end
                        if (w_cnt == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= (w_err || w_beat_err)
                                     ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            wready <= NO_STALL;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // In R_IDLE the generator looks at the incoming AR request so the
    // first beat can be presented the cycle after the handshake.
    always_comb begin
        if (r_state == R_IDLE) begin
            r_gen_addr  = araddr;
            r_gen_len   = arlen;
            r_gen_size  = arsize;
            r_gen_burst = burst_type_e'(arburst);
            r_id_sel    = arid;
            r_cnt_sel   = 8'd0;
        end else begin
            r_gen_addr  = r_addr;
            r_gen_len   = r_len;
            r_gen_size  = r_size;
            r_gen_burst = r_burst;
            r_id_sel    = r_id;
            r_cnt_sel   = r_cnt;
        end
        r_ok    = r_legal && r_in_range;
        r_idx   = r_gen_addr[LANE_BITS +: IDX_W];
        r_fetch = ((r_state == R_IDLE) && arvalid && arready && NO_STALL)
               || ((r_state == R_DATA) && rvalid && rready && !rlast
                   && NO_STALL)
               || ((r_state == R_DATA) && !rvalid
                   && (r_wait == WAIT_LAST));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rid     <= '0;
            rdata   <= '0;
            rlast   <= 1'b0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= 8'd0;
            r_size  <= 3'd0;
            r_burst <= BURST_FIXED;
            r_cnt   <= 8'd0;
            r_wait  <= 8'd0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        r_id    <= arid;
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= burst_type_e'(arburst);
                        r_cnt   <= 8'd0;
                        r_wait  <= 8'd0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (!rvalid) begin
                        r_wait <= r_wait + 8'd1;
                    end else if (rready) begin
                        rvalid <= 1'b0;
                        if (rlast) begin
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
            // mem read here returns pre-write data on a same-cycle write
            if (r_fetch) begin
                rvalid <= 1'b1;
                rid    <= r_id_sel;
                rdata  <= r_ok ? mem[r_idx] : '0;
                rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
                rlast  <= (r_cnt_sel == r_gen_len);
                r_addr <= r_next;
                r_cnt  <= r_cnt_sel + 8'd1;
                r_wait <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// tb_ei_axi4_slave_mem: directed bench for ei_axi4_slave_mem.
// Drives AXI bursts and checks responses against hand-computed values.
module tb_ei_axi4_slave_mem;

    localparam int LIMIT = 50;
`ifdef EI_AXI4_SLV_WAIT_EN
    localparam int STALL_EXP = 2;
`else
    localparam int STALL_EXP = 0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    ei_axi4_slave_mem dut (
        .aclk    (aclk),    .aresetn (aresetn),
        .awid    (awid),    .awaddr  (awaddr),
        .awlen   (awlen),   .awsize  (awsize),
        .awburst (awburst), .awvalid (awvalid),
        .awready (awready), .wdata   (wdata),
        .wstrb   (wstrb),   .wlast   (wlast),
        .wvalid  (wvalid),  .wready  (wready),
        .bid     (bid),     .bresp   (bresp),
        .bvalid  (bvalid),  .bready  (bready),
        .arid    (arid),    .araddr  (araddr),
        .arlen   (arlen),   .arsize  (arsize),
        .arburst (arburst), .arvalid (arvalid),
        .arready (arready), .rid     (rid),
        .rdata   (rdata),   .rresp   (rresp),
        .rlast   (rlast),   .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    logic [3:0]  rid_seen;
    int          w_mid_wait;
    int          r_first_wait;
    logic [1:0]  resp;
    logic [3:0]  bid_o;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [3:0] strb,
                               input int last_at, output logic [1:0] rsp,
                               output logic [3:0] id_o);
        int n;
        awid = id; awaddr = addr; awlen = len;
        awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < LIMIT) begin tick(); n++; end
        check("aw_handshake", n < LIMIT, 1);
        tick();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbuf[b]; wstrb = strb;
            wlast = (b == last_at); wvalid = 1'b1;
            n = 0;
            while (!wready && n < LIMIT) begin tick(); n++; end
            if (b == 1) w_mid_wait = n;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < LIMIT) begin tick(); n++; end
        check("b_handshake", n < LIMIT, 1);
        rsp = bresp; id_o = bid;
        tick();
        bready = 1'b0;
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst);
        int n;
        arid = id; araddr = addr; arlen = len;
        arsize = size; arburst = burst; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < LIMIT) begin tick(); n++; end
        check("ar_handshake", n < LIMIT, 1);
        tick();
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < LIMIT) begin tick(); n++; end
            if (b == 0) begin
                r_first_wait = n;
                rid_seen = rid;
            end
            rbuf[b] = rdata; rrsp[b] = rresp; rlst[b] = rlast;
            tick();
        end
        rready = 1'b0;
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) tick();
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bid", bid, 0);
        check("rst_rid", rid, 0);
        aresetn = 1'b1;
        tick();
        check("awready_after_rst", awready, 1);
        check("arready_after_rst", arready, 1);

        // INCR 0x10 len 3 size 2
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        write_burst(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 4'hF, 3, resp, bid_o);
        check("incr_bresp", resp, 0);
        check("incr_bid", bid_o, 5);
        check("w_stall", w_mid_wait, STALL_EXP);
        read_burst(4'h9, 32'h10, 8'd3, 3'd2, 2'b01);
        check("r_first_latency", r_first_wait, STALL_EXP);
        check("incr_rid", rid_seen, 9);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_rdata%0d", i), rbuf[i], i + 1);
            check($sformatf("incr_rresp%0d", i), rrsp[i], 0);
            check($sformatf("incr_rlast%0d", i), rlst[i], i == 3);
        end

        // WRAP 0x38 len 3: beats land at 0x38,0x3C,0x30,0x34
        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1;
        wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
        write_burst(4'h2, 32'h38, 8'd3, 3'd2, 2'b10, 4'hF, 3, resp, bid_o);
        check("wrap_bresp", resp, 0);
        read_burst(4'h2, 32'h38, 8'd3, 3'd2, 2'b10);
        check("wrap_rd0", rbuf[0], 32'hA0);
        check("wrap_rd3", rbuf[3], 32'hA3);
        read_burst(4'h3, 32'h30, 8'd3, 3'd2, 2'b01);
        check("wrap_mem30", rbuf[0], 32'hA2);
        check("wrap_mem34", rbuf[1], 32'hA3);
        check("wrap_mem38", rbuf[2], 32'hA0);
        check("wrap_mem3c", rbuf[3], 32'hA1);

        // out of range: 0x1010 aliases word 0x10 if the guard is missing
        wbuf[0] = 32'hDEADBEEF;
        write_burst(4'h1, 32'h1010, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp, bid_o);
        check("oor_bresp", resp, 2);
        read_burst(4'h1, 32'h10, 8'd0, 3'd2, 2'b01);
        check("oor_mem_intact", rbuf[0], 32'h1);
        read_burst(4'h1, 32'h1000, 8'd0, 3'd2, 2'b01);
        check("oor_rdata", rbuf[0], 0);
        check("oor_rresp", rrsp[0], 2);
        wbuf[0] = 32'hCAFE0FFC;
        write_burst(4'h1, 32'hFFC, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp, bid_o);
        check("top_word_bresp", resp, 0);
        read_burst(4'h1, 32'hFFC, 8'd1, 3'd2, 2'b01);
        check("edge_rd0", rbuf[0], 32'hCAFE0FFC);
        check("edge_rresp0", rrsp[0], 0);
        check("edge_rd1", rbuf[1], 0);
        check("edge_rresp1", rrsp[1], 2);

        // early wlast
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h80 + 32'(i);
        write_burst(4'h6, 32'h80, 8'd3, 3'd2, 2'b01, 4'hF, 1, resp, bid_o);
        check("early_wlast_bresp", resp, 2);
        check("early_wlast_bid", bid_o, 6);

        // illegal bursts
        wbuf[0] = 32'h90909090;
        write_burst(4'h0, 32'h90, 8'd0, 3'd2, 2'b01, 4'hF, 0, resp, bid_o);
        wbuf[0] = 32'h11111111;
        write_burst(4'h0, 32'h90, 8'd0, 3'd3, 2'b01, 4'hF, 0, resp, bid_o);
        check("bad_size_bresp", resp, 2);
        read_burst(4'h0, 32'h90, 8'd0, 3'd2, 2'b01);
        check("bad_size_no_write", rbuf[0], 32'h90909090);
        read_burst(4'h0, 32'h30, 8'd2, 3'd2, 2'b10);
        check("bad_wrap_rresp0", rrsp[0], 2);
        check("bad_wrap_rdata2", rbuf[2], 0);
        check("bad_wrap_rlast2", rlst[2], 1);
        read_burst(4'h0, 32'h90, 8'd0, 3'd2, 2'b11);
        check("rsvd_burst_rresp", rrsp[0], 2);

        // FIXED: all beats hit the start word
        wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3C3C;
        write_burst(4'h4, 32'h40, 8'd2, 3'd2, 2'b00, 4'hF, 2, resp, bid_o);
        check("fixed_bresp", resp, 0);
        read_burst(4'h4, 32'h40, 8'd1, 3'd2, 2'b00);
        check("fixed_rd0", rbuf[0], 32'h3C3C);
        check("fixed_rd1", rbuf[1], 32'h3C3C);

        // rready held low 5 cycles
        arid = 4'hB; araddr = 32'h10; arlen = 8'd1;
        arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < LIMIT) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < LIMIT) begin tick(); n++; end
        check("hold_rvalid_up", n < LIMIT, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_rvalid", rvalid, 1);
            check("hold_rdata", rdata, 1);
            check("hold_rlast", rlast, 0);
            check("hold_rid", rid, 4'hB);
        end
        rready = 1'b1;
        tick();
        n = 0;
        while (!rvalid && n < LIMIT) begin tick(); n++; end
        check("hold_beat1_data", rdata, 2);
        check("hold_beat1_last", rlast, 1);
        tick();
        rready = 1'b0;

        // reset mid-write burst
        awid = 4'h7; awaddr = 32'h200; awlen = 8'd3;
        awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        while (!awready && n < LIMIT) begin tick(); n++; end
        tick();
        awvalid = 1'b0;
        check("awready_busy", awready, 0);
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        n = 0;
        while (!wready && n < LIMIT) begin tick(); n++; end
        tick();
        aresetn = 1'b0;
        tick();
        wvalid = 1'b0;
        check("midrst_wready", wready, 0);
        check("midrst_bvalid", bvalid, 0);
        check("midrst_awready", awready, 0);
        check("midrst_rvalid", rvalid, 0);
        aresetn = 1'b1;
        bready = 1'b1;
        repeat (6) tick();
        check("midrst_no_b", bvalid, 0);
        check("midrst_idle", awready, 1);
        bready = 1'b0;
        read_burst(4'h1, 32'h10, 8'd3, 3'd2, 2'b01);
        check("midrst_mem10", rbuf[0], 1);
        check("midrst_mem1c", rbuf[3], 4);

        // byte strobes on word 0x14 (old value 2)
        wbuf[0] = 32'hAABBCCDD;
        write_burst(4'h1, 32'h14, 8'd0, 3'd2, 2'b01, 4'h5, 0, resp, bid_o);
        read_burst(4'h1, 32'h14, 8'd0, 3'd2, 2'b01);
        check("strobe_merge", rbuf[0], 32'h00BB00DD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
